// File: rtl/display_pkg.sv
// Shared seven-segment types and the active-low glyph table for the HEX displays.
package display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef logic [6:0]      seg_t;
    typedef logic [5:0][3:0] hex6_t;

    // Active-low, bit0 = segment a ... bit6 = segment g
    function automatic seg_t hex_to_seg(input logic [3:0] v);
        seg_t s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/value_to_seven_seg.sv
// One hex digit to an active-low segment pattern, with forced blanking.
module value_to_seven_seg
    import display_pkg::*;
(
    input  logic [3:0] value_i,
    input  logic       blank_i,
    output seg_t       seg_o
);

    assign seg_o = blank_i ? SEG_BLANK : hex_to_seg(value_i);

endmodule

// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter sharing the six HEX displays between requesters,
// holding each granted value for a minimum dwell time.
module hex_display_arbiter
    import display_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int DWELL_CYCLES  = 8,
    parameter int BLANK_LEADING = 1,
    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0][23:0]     req_value,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [OW-1:0]                owner,
    output logic                         owner_valid,
    output logic [6:0]                   HEX0,
    output logic [6:0]                   HEX1,
    output logic [6:0]                   HEX2,
    output logic [6:0]                   HEX3,
    output logic [6:0]                   HEX4,
    output logic [6:0]                   HEX5
);

    localparam int DW = $clog2(DWELL_CYCLES + 1);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t          state_q;
    logic [DW-1:0]   dwell_q;
    logic [OW-1:0]   rr_ptr_q;
    logic [OW-1:0]   owner_q;
    logic            owner_valid_q;
    hex6_t           value_q;
    hex6_t           value_d;
    seg_t [5:0]      hex_q;
    seg_t [5:0]      seg_d;
    logic [5:0]      blank_d;

    logic            found;
    logic [OW-1:0]   winner;
    logic [OW-1:0]   sel;
    logic            transfer;

    always_comb begin
        int idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!found && req_valid[OW'(idx)]) begin
                found  = 1'b1;
                winner = OW'(idx);
            end
        end
    end

    assign sel       = (state_q == IDLE) ? winner : owner_q;
    assign req_ready = (!reset && (state_q == SHOW || found)) ? (NUM_REQ'(1) << sel) : '0;
    assign transfer  = |(req_valid & req_ready);
    assign value_d   = transfer ? hex6_t'(req_value[sel]) : value_q;

    // Segments are encoded from the next value so HEX lands on the transfer edge.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        blank_d  = '0;
        for (int k = 5; k >= 1; k--) begin
            zero_run   = zero_run && (value_d[k] == 4'h0);
            blank_d[k] = (BLANK_LEADING != 0) && zero_run;
        end
    end

    for (genvar g = 0; g < 6; g++) begin : g_seg
        value_to_seven_seg u_seg (
            .value_i (value_d[g]),
            .blank_i (blank_d[g]),
            .seg_o   (seg_d[g])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            dwell_q       <= '0;
            owner_q       <= '0;
            owner_valid_q <= 1'b0;
            value_q       <= '0;
            hex_q         <= {6{SEG_BLANK}};
        end else begin
            value_q <= value_d;
            hex_q   <= seg_d;
            case (state_q)
                IDLE: begin
                    if (transfer) begin
                        owner_q       <= winner;
                        owner_valid_q <= 1'b1;
                        rr_ptr_q      <= (winner == OW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                        dwell_q       <= DW'(DWELL_CYCLES - 1);
                        state_q       <= SHOW;
                    end
                end
                SHOW: begin
                    // Owner refreshes update the value only; the dwell keeps running.
                    if (dwell_q == '0) begin
                        state_q       <= IDLE;
                        owner_valid_q <= 1'b0;
                    end else begin
                        dwell_q <= dwell_q - 1'b1;
                    end
                end
            endcase
        end
    end

    assign owner       = owner_q;
    assign owner_valid = owner_valid_q;
    assign HEX0        = hex_q[0];
    assign HEX1        = hex_q[1];
    assign HEX2        = hex_q[2];
    assign HEX3        = hex_q[3];
    assign HEX4        = hex_q[4];
    assign HEX5        = hex_q[5];

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Directed bench for hex_display_arbiter (NUM_REQ = 2, DWELL_CYCLES = 4).
module tb_hex_display_arbiter;

    logic              clock = 1'b0;
    logic              reset;
    logic [1:0]        req_valid;
    logic [1:0][23:0]  req_value;
    logic [1:0]        req_ready, req_ready0;
    logic              owner, owner0;
    logic              owner_valid, owner_valid0;
    logic [6:0]        h0, h1, h2, h3, h4, h5;
    logic [6:0]        z0, z1, z2, z3, z4, z5;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [4:0] B = 5'h10;

    always #5 clock = ~clock;

    hex_display_arbiter #(.NUM_REQ(2), .DWELL_CYCLES(4), .BLANK_LEADING(1)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_value(req_value),
        .req_ready(req_ready), .owner(owner), .owner_valid(owner_valid),
        .HEX0(h0), .HEX1(h1), .HEX2(h2), .HEX3(h3), .HEX4(h4), .HEX5(h5)
    );

    hex_display_arbiter #(.NUM_REQ(2), .DWELL_CYCLES(4), .BLANK_LEADING(0)) dut_nb (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_value(req_value),
        .req_ready(req_ready0), .owner(owner0), .owner_valid(owner_valid0),
        .HEX0(z0), .HEX1(z1), .HEX2(z2), .HEX3(z3), .HEX4(z4), .HEX5(z5)
    );

    function automatic logic [4:0] sevenSegToValue(input logic [6:0] s);
        case (s)
            7'h40: return 5'h0;  7'h79: return 5'h1;  7'h24: return 5'h2;  7'h30: return 5'h3;
            7'h19: return 5'h4;  7'h12: return 5'h5;  7'h02: return 5'h6;  7'h78: return 5'h7;
            7'h00: return 5'h8;  7'h10: return 5'h9;  7'h08: return 5'hA;  7'h03: return 5'hB;
            7'h46: return 5'hC;  7'h21: return 5'hD;  7'h06: return 5'hE;  7'h0E: return 5'hF;
            7'h7F: return B;
            default: return 5'h1F;
        endcase
    endfunction

    logic [29:0] disp, disp_nb;
    assign disp    = {sevenSegToValue(h5), sevenSegToValue(h4), sevenSegToValue(h3),
                      sevenSegToValue(h2), sevenSegToValue(h1), sevenSegToValue(h0)};
    assign disp_nb = {sevenSegToValue(z5), sevenSegToValue(z4), sevenSegToValue(z3),
                      sevenSegToValue(z2), sevenSegToValue(z1), sevenSegToValue(z0)};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 2'b00; req_value = '0;
        tick(); tick();
        n_checks++;
        if ({h5, h4, h3, h2, h1, h0} !== {6{7'h7F}}) begin
            n_fail++; $display("FAIL reset_hex: got %h want all 7F", {h5, h4, h3, h2, h1, h0});
        end
        n_checks++;
        if (owner_valid !== 1'b0 || req_ready !== 2'b00) begin
            n_fail++; $display("FAIL reset_ctrl: ov=%b ready=%b want 0/00", owner_valid, req_ready);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        int cnt;
        req_value[0] = 24'h0012AB; req_valid = 2'b01;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++; $display("FAIL single_ready: got %b want 01", req_ready);
        end
        tick();
        req_valid = 2'b00;
        n_checks++;
        if ({h5, h4, h3, h2, h1, h0} !== {7'h7F, 7'h7F, 7'h79, 7'h24, 7'h08, 7'h03}) begin
            n_fail++; $display("FAIL single_hex: got %h want 7F7F792408 03", {h5, h4, h3, h2, h1, h0});
        end
        n_checks++;
        if (owner !== 1'b0 || owner_valid !== 1'b1) begin
            n_fail++; $display("FAIL single_owner: owner=%b ov=%b want 0/1", owner, owner_valid);
        end
        cnt = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (owner_valid === 1'b1) cnt++;
        end
        n_checks++;
        if (cnt !== 4) begin
            n_fail++; $display("FAIL single_dwell: owner_valid cycles %0d want 4", cnt);
        end
        n_checks++;
        if (disp !== {B, B, 5'h1, 5'h2, 5'hA, 5'hB}) begin
            n_fail++; $display("FAIL single_hold: got %h want display 12AB kept", disp);
        end
    endtask

    task automatic test_round_robin();
        logic exp_o;
        reset = 1'b1; tick(); reset = 1'b0;
        req_value[0] = 24'h111111; req_value[1] = 24'h222222; req_valid = 2'b11;
        #1;
        for (int g = 0; g < 4; g++) begin
            exp_o = g[0];
            n_checks++;
            if (req_ready !== (exp_o ? 2'b10 : 2'b01)) begin
                n_fail++; $display("FAIL rr_ready%0d: got %b want grant %0d", g, req_ready, exp_o);
            end
            for (int c = 0; c < 4; c++) begin
                tick();
                n_checks++;
                if (owner_valid !== 1'b1 || owner !== exp_o ||
                    disp !== (exp_o ? {6{5'h2}} : {6{5'h1}})) begin
                    n_fail++;
                    $display("FAIL rr_show%0d_%0d: ov=%b owner=%b disp=%h want 1/%0d", g, c,
                             owner_valid, owner, disp, exp_o);
                end
            end
            tick();
            n_checks++;
            if (owner_valid !== 1'b0 || disp !== (exp_o ? {6{5'h2}} : {6{5'h1}})) begin
                n_fail++; $display("FAIL rr_idle%0d: ov=%b disp=%h want 0 and held", g, owner_valid, disp);
            end
        end
        req_valid = 2'b00;
    endtask

    task automatic test_refresh();
        reset = 1'b1; tick(); reset = 1'b0;
        req_value[0] = 24'h111111; req_valid = 2'b01;
        tick();
        req_value[0] = 24'h000005;
        tick();
        n_checks++;
        if ({h5, h4, h3, h2, h1, h0} !== {{5{7'h7F}}, 7'h12} || owner_valid !== 1'b1) begin
            n_fail++; $display("FAIL refresh_hex: got %h ov=%b want 7F..12 / 1", {h5, h4, h3, h2, h1, h0}, owner_valid);
        end
        tick(); tick();
        n_checks++;
        if (owner_valid !== 1'b1) begin
            n_fail++; $display("FAIL refresh_last: ov=%b want 1", owner_valid);
        end
        // Refresh on the expiry edge: value updates, SHOW still ends
        req_value[0] = 24'h000007;
        tick();
        n_checks++;
        if (owner_valid !== 1'b0 || disp !== {B, B, B, B, B, 5'h7}) begin
            n_fail++; $display("FAIL refresh_expiry: ov=%b disp=%h want 0 and 7", owner_valid, disp);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_reset_mid_show();
        req_value[0] = 24'h000001; req_value[1] = 24'h000002; req_valid = 2'b11;
        #1;
        n_checks++;
        if (req_ready !== 2'b10) begin
            n_fail++; $display("FAIL midrst_first: got %b want 10", req_ready);
        end
        tick(); tick();
        reset = 1'b1; req_valid = 2'b00;
        tick();
        n_checks++;
        if ({h5, h4, h3, h2, h1, h0} !== {6{7'h7F}} || owner_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_state: hex=%h ov=%b want 7F.. / 0", {h5, h4, h3, h2, h1, h0}, owner_valid);
        end
        reset = 1'b0; req_valid = 2'b11;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++; $display("FAIL midrst_rrptr: got %b want 01", req_ready);
        end
        tick();
        n_checks++;
        if (owner !== 1'b0 || disp !== {B, B, B, B, B, 5'h1}) begin
            n_fail++; $display("FAIL midrst_grant: owner=%b disp=%h want 0 / 1", owner, disp);
        end
        req_valid = 2'b00;
        for (int i = 0; i < 5; i++) tick();
    endtask

    task automatic test_no_blank();
        reset = 1'b1; tick(); reset = 1'b0;
        req_value[0] = 24'h000000; req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        n_checks++;
        if ({z5, z4, z3, z2, z1, z0} !== {6{7'h40}}) begin
            n_fail++; $display("FAIL noblank_zero: got %h want all 40", {z5, z4, z3, z2, z1, z0});
        end
        n_checks++;
        if ({h5, h4, h3, h2, h1, h0} !== {{5{7'h7F}}, 7'h40}) begin
            n_fail++; $display("FAIL blank_zero: got %h want 7F.. 40", {h5, h4, h3, h2, h1, h0});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_refresh();
        test_reset_mid_show();
        test_no_blank();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
